// File: rtl/empty_ptr_storage_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : empty_ptr_storage_if                                          |
// | Description : Handshake bundle between the free-address pool and its users: |
// |               free-address offer to insert, address return from delete,     |
// |               and pool status.                                              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

`ifndef TABLE_ADDR_WIDTH
`define TABLE_ADDR_WIDTH 4
`endif

interface empty_ptr_storage_if #(
  parameter int A_WIDTH = `TABLE_ADDR_WIDTH
);
  // Offer side (pool -> insert)
  logic [A_WIDTH-1:0] empty_addr_o;
  logic               empty_addr_val_o;
  logic               empty_addr_rd_ack_i;
  // Return side (delete -> pool)
  logic [A_WIDTH-1:0] add_addr_i;
  logic               add_addr_val_i;
  logic               add_addr_ready_o;
  // Status
  logic               init_done_o;
  logic [A_WIDTH:0]   free_cnt_o;
  logic               err_o;

  // Pool side
  modport slave (
    output empty_addr_o, empty_addr_val_o, add_addr_ready_o,
           init_done_o, free_cnt_o, err_o,
    input  empty_addr_rd_ack_i, add_addr_i, add_addr_val_i
  );

  // User side (insert / delete engines)
  modport master (
    input  empty_addr_o, empty_addr_val_o, add_addr_ready_o,
           init_done_o, free_cnt_o, err_o,
    output empty_addr_rd_ack_i, add_addr_i, add_addr_val_i
  );
endinterface

`default_nettype wire

// File: rtl/empty_ptr_storage.sv
// +-----------------------------------------------------------------------------+
// | Module      : empty_ptr_storage                                             |
// | Description : FIFO pool of unused hash-table data addresses. Self-fills     |
// |               with 0..2^A_WIDTH-1 after reset, offers one address at a time |
// |               and accepts returned addresses.                               |
// |               Optional macro EMPTY_PTR_DOUBLE_FREE_CHECK_EN adds a per-     |
// |               address "in use" bitmap that rejects double frees.            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

`ifndef TABLE_ADDR_WIDTH
`define TABLE_ADDR_WIDTH 4
`endif

module empty_ptr_storage #(
  parameter int A_WIDTH = `TABLE_ADDR_WIDTH
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  empty_ptr_storage_if.slave  bus
);

  localparam int DEPTH = 1 << A_WIDTH;

  typedef enum logic [0:0] {
    INIT_S = 1'b0,
    RUN_S  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  // The write pointer doubles as the init counter: it walks 0..DEPTH-1 and
  // wraps back to 0, which is exactly where the first returned address goes.
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  // The RAM read register is the output register itself, so a read issued at
  // an edge lands in out_addr at that same edge and nothing is ever in flight
  // between clock edges.
  logic [A_WIDTH-1:0] out_addr_q, out_addr_d;
  logic               out_val_q, out_val_d;
  logic               err_q, err_d;

  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_wdata;

  logic               ack;
  logic               rd_en;
  logic               add_req;
  logic               add_ok;
  logic               used_ok;
  logic               full;
  logic [A_WIDTH:0]   free_cnt;

  assign free_cnt = mem_cnt_q + (A_WIDTH+1)'(out_val_q);
  assign full     = (free_cnt == (A_WIDTH+1)'(DEPTH));
  assign ack      = bus.empty_addr_rd_ack_i & out_val_q;

`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] used_q, used_d;

  // A return is legal only for an address currently handed out; an ack of the
  // same address in this very cycle counts as handed out.
  assign used_ok = used_q[bus.add_addr_i] | (ack & (out_addr_q == bus.add_addr_i));

  // Track which addresses are held by the table: set on hand-out, clear on return
  always_comb begin
    used_d = used_q;
    if (ack) begin
      used_d[out_addr_q] = 1'b1;
    end
    if (add_ok) begin
      used_d[bus.add_addr_i] = 1'b0;
    end
  end

  // Bitmap register, all addresses free after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end
`else
  assign used_ok = 1'b1;
`endif

  // Next-state, pointer, counter and output-register logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    out_addr_d = out_addr_q;
    out_val_d  = out_val_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wdata  = wr_ptr_q;
    rd_en      = 1'b0;
    add_req    = 1'b0;
    add_ok     = 1'b0;

    case (state_q)
      INIT_S: begin
        mem_we    = 1'b1;
        mem_wdata = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        mem_cnt_d = mem_cnt_q + (A_WIDTH+1)'(1);
        if (wr_ptr_q == A_WIDTH'(DEPTH - 1)) begin
          state_d = RUN_S;
        end
      end

      RUN_S: begin
        add_req = bus.add_addr_val_i;
        add_ok  = add_req & ~full & used_ok;
        rd_en   = ~out_val_q & (mem_cnt_q != '0);

        // A rejected return is either an overflow or a double free
        if (add_req && !add_ok) begin
          err_d = 1'b1;
        end

        if (add_ok) begin
          mem_we    = 1'b1;
          mem_wdata = bus.add_addr_i;
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end

        mem_cnt_d = mem_cnt_q + (A_WIDTH+1)'(add_ok) - (A_WIDTH+1)'(rd_en);

        if (ack) begin
          out_val_d = 1'b0;
        end

        // Refill only from an empty output register, so the offered address
        // stays put until the edge after its ack.
        if (rd_en) begin
          out_addr_d = mem_q[rd_ptr_q];
          out_val_d  = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end
      end

      default: begin
        state_d = INIT_S;
      end
    endcase
  end

  // State, pointers, counter, output register and sticky error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT_S;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_addr_q <= '0;
      out_val_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      out_addr_q <= out_addr_d;
      out_val_q  <= out_val_d;
      err_q      <= err_d;
    end
  end

  // Pool storage RAM write port; contents are rebuilt by the init sweep
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign bus.empty_addr_o     = out_addr_q;
  assign bus.empty_addr_val_o = out_val_q;
  assign bus.add_addr_ready_o = (state_q == RUN_S);
  assign bus.init_done_o      = (state_q == RUN_S);
  assign bus.free_cnt_o       = free_cnt;
  assign bus.err_o            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_empty_ptr_storage.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_empty_ptr_storage                                          |
// | Description : Self-checking bench for empty_ptr_storage. A queue-level      |
// |               model of the free pool predicts every output each cycle;      |
// |               directed steps cover init timing, drain, refill, ack+add,     |
// |               overflow and mid-run reset, followed by random traffic.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_empty_ptr_storage;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  empty_ptr_storage_if #(.A_WIDTH(AW)) bus ();

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: the pool as a queue of addresses waiting behind the
  // offered one, plus the set of addresses currently held by the table.
  int fifo[$];
  int outst[$];
  bit m_val;
  int m_addr;
  bit m_err;
  int m_init;
  bit m_used[DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    fifo.delete();
    outst.delete();
    m_val  = 1'b0;
    m_addr = 0;
    m_err  = 1'b0;
    m_init = 0;
    for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  32'(bus.empty_addr_o),     0);
    check({tag, "_val"},   32'(bus.empty_addr_val_o), 0);
    check({tag, "_ready"}, 32'(bus.add_addr_ready_o), 0);
    check({tag, "_done"},  32'(bus.init_done_o),      0);
    check({tag, "_free"},  32'(bus.free_cnt_o),       0);
    check({tag, "_err"},   32'(bus.err_o),            0);
  endtask

  task automatic check_outputs();
    if (m_init < DEPTH) begin
      check("init_done", 32'(bus.init_done_o),      0);
      check("ready",     32'(bus.add_addr_ready_o), 0);
      check("val",       32'(bus.empty_addr_val_o), 0);
      check("free_cnt",  32'(bus.free_cnt_o),       32'(m_init));
      check("err",       32'(bus.err_o),            0);
    end else begin
      check("init_done", 32'(bus.init_done_o),      1);
      check("ready",     32'(bus.add_addr_ready_o), 1);
      check("val",       32'(bus.empty_addr_val_o), 32'(m_val));
      if (m_val) check("addr", 32'(bus.empty_addr_o), 32'(m_addr));
      check("free_cnt",  32'(bus.free_cnt_o),       32'(fifo.size() + int'(m_val)));
      check("err",       32'(bus.err_o),            32'(m_err));
    end
  endtask

  task automatic drop_outst(input int a);
    for (int i = 0; i < outst.size(); i++) begin
      if (outst[i] == a) begin
        outst.delete(i);
        break;
      end
    end
  endtask

  task automatic model_step(input logic ack, input logic addv, input int adda);
    bit full;
    bit hit;
    bit pop;
    bit ok;
    if (m_init < DEPTH) begin
      m_init++;
      if (m_init == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) fifo.push_back(i);
      end
    end else begin
      full = ((fifo.size() + int'(m_val)) == DEPTH);
      hit  = ack && m_val;
      pop  = !m_val && (fifo.size() > 0);
`ifdef EMPTY_PTR_DOUBLE_FREE_CHECK_EN
      ok = !full && (m_used[adda] || (hit && (m_addr == adda)));
`else
      ok = !full;
`endif
      if (hit) begin
        m_used[m_addr] = 1'b1;
        outst.push_back(m_addr);
        m_val = 1'b0;
      end
      if (addv) begin
        if (ok) begin
          fifo.push_back(adda);
          m_used[adda] = 1'b0;
          drop_outst(adda);
        end else begin
          m_err = 1'b1;
        end
      end
      if (pop) begin
        m_addr = fifo.pop_front();
        m_val  = 1'b1;
      end
    end
  endtask

  // One clock period: compare outputs, drive inputs, advance model, step clock
  task automatic do_cycle(input logic ack, input logic addv, input logic [AW-1:0] adda);
    check_outputs();
    bus.empty_addr_rd_ack_i = ack;
    bus.add_addr_val_i      = addv;
    bus.add_addr_i          = adda;
    model_step(ack, addv, int'(adda));
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    bus.empty_addr_rd_ack_i = 1'b0;
    bus.add_addr_val_i      = 1'b0;
    bus.add_addr_i          = '0;
    #1;
    check_reset_values("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  task automatic wait_val();
    int n;
    n = 0;
    while (bus.empty_addr_val_o !== 1'b1 && n < 8) begin
      do_cycle(1'b0, 1'b0, '0);
      n++;
    end
    check("wait_val_timeout", 32'(bus.empty_addr_val_o), 1);
  endtask

  task automatic ack_n(input int n);
    for (int k = 0; k < n; k++) begin
      wait_val();
      do_cycle(1'b1, 1'b0, '0);
    end
  endtask

  task automatic idle_to_first_offer();
    for (int n = 0; n < 18; n++) begin
      if (cyc == 15) check("init_done_c15", 32'(bus.init_done_o), 0);
      if (cyc == 16) check("init_done_c16", 32'(bus.init_done_o), 1);
      if (cyc == 17) begin
        check("first_val_c17",  32'(bus.empty_addr_val_o), 1);
        check("first_addr_c17", 32'(bus.empty_addr_o),     0);
        check("first_free_c17", 32'(bus.free_cnt_o),       16);
      end
      do_cycle(1'b0, 1'b0, '0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int got;
    int prev;
    int budget;
    int n0;
    int ret_list[13];
    logic a;
    logic v;
    logic [AW-1:0] ad;
    int idx;

    bus.empty_addr_rd_ack_i = 1'b0;
    bus.add_addr_val_i      = 1'b0;
    bus.add_addr_i          = '0;

    // Reset and idle through init
    apply_reset();
    idle_to_first_offer();

    // Drain the whole pool, acking each offer as soon as it appears
    got = 0; prev = -1; budget = 0;
    while (got < DEPTH && budget < 60) begin
      if (bus.empty_addr_val_o === 1'b1) begin
        check("chain_addr", 32'(bus.empty_addr_o), 32'(got));
        if (prev >= 0) check("chain_spacing", 32'(cyc - prev), 2);
        prev = cyc;
        got++;
        do_cycle(1'b1, 1'b0, '0);
      end else begin
        do_cycle(1'b0, 1'b0, '0);
      end
      budget++;
    end
    check("chain_count", 32'(got), 16);
    do_cycle(1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b0, '0);
    check("drained_val",  32'(bus.empty_addr_val_o), 0);
    check("drained_free", 32'(bus.free_cnt_o),       0);
    check("drained_err",  32'(bus.err_o),            0);

    // Return address 9 into the empty pool
    n0 = cyc;
    do_cycle(1'b0, 1'b1, 4'd9);
    check("add9_n1_val", 32'(bus.empty_addr_val_o), 0);
    do_cycle(1'b0, 1'b0, '0);
    check("add9_n2_cycle", 32'(cyc - n0), 2);
    check("add9_n2_val",  32'(bus.empty_addr_val_o), 1);
    check("add9_n2_addr", 32'(bus.empty_addr_o),     9);
    check("add9_n2_free", 32'(bus.free_cnt_o),       1);

    // Queue 3 followed by twelve others, then ack 3 while returning 3
    do_cycle(1'b1, 1'b0, '0);
    ret_list = '{3, 0, 1, 2, 4, 5, 6, 7, 8, 10, 11, 12, 13};
    for (int k = 0; k < 13; k++) do_cycle(1'b0, 1'b1, AW'(ret_list[k]));
    wait_val();
    check("ackadd_pre_addr", 32'(bus.empty_addr_o), 3);
    check("ackadd_pre_free", 32'(bus.free_cnt_o),   13);
    do_cycle(1'b1, 1'b1, 4'd3);
    check("ackadd_post_free", 32'(bus.free_cnt_o), 13);
    ack_n(12);
    wait_val();
    check("ackadd_reappear", 32'(bus.empty_addr_o), 3);

    // Random traffic: acks at random, returns drawn from held addresses
    for (int n = 0; n < 500; n++) begin
      a  = ($urandom_range(0, 1) == 1);
      v  = 1'b0;
      ad = '0;
      if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, outst.size() - 1));
        ad  = AW'(outst[idx]);
        v   = 1'b1;
      end
      do_cycle(a, v, ad);
    end

    // Return to a full pool: dropped and flagged
    apply_reset();
    idle_to_first_offer();
    do_cycle(1'b0, 1'b1, 4'd5);
    check("ovf_err",  32'(bus.err_o),            1);
    check("ovf_free", 32'(bus.free_cnt_o),       16);
    check("ovf_val",  32'(bus.empty_addr_val_o), 1);
    check("ovf_addr", 32'(bus.empty_addr_o),     0);
    do_cycle(1'b0, 1'b0, '0);
    check("ovf_err_sticky", 32'(bus.err_o), 1);

    // Reset in the middle of a hand-out chain
    apply_reset();
    idle_to_first_offer();
    ack_n(5);
    apply_reset();
    idle_to_first_offer();
    check("rerun_err", 32'(bus.err_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-address pool for the hash table data RAM. Holds every currently unused data-table address in a FIFO and presents one at a time to the insert engine (`empty_addr_i` / `empty_addr_val_i` / `empty_addr_rd_ack_o` of the insert stage). Addresses released by the delete path are returned through a valid/ready port. After reset it self-initialises to contain all addresses `0 .. 2^A_WIDTH-1`.

## Interface
- `A_WIDTH`, default `TABLE_ADDR_WIDTH`: data-table address width. DEPTH = 2^A_WIDTH.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `empty_addr_o`  out  A_WIDTH  current free address offered to insert.
- `empty_addr_val_o`  out  1  `empty_addr_o` is a valid free address.
- `empty_addr_rd_ack_i`  in  1  insert consumed `empty_addr_o`. Ignored when val=0.
- `add_addr_i`  in  A_WIDTH  address being returned to the pool.
- `add_addr_val_i`  in  1  return request.
- `add_addr_ready_o`  out  1  return accepted when val&ready.
- `init_done_o`  out  1  initial fill complete.
- `free_cnt_o`  out  A_WIDTH+1  free addresses held, FIFO memory plus output register.
- `err_o`  out  1  sticky error flag, cleared only by reset.

## Operation
- Storage:
  - DEPTH-entry RAM with 1-cycle registered read.
  - Write and read pointers, A_WIDTH bits, wrap modulo DEPTH.
  - `mem_cnt`, A_WIDTH+1 bits.
  - Output register `out_addr` / `out_val` drives `empty_addr_o` / `empty_addr_val_o`.
- States:
  - INIT_S: entered on reset. Counter `i` writes `mem[i]=i` for one address per cycle, and `mem_cnt` increments each cycle. After writing `DEPTH-1`, go to RUN_S. `add_addr_ready_o=0` and `out_val=0` throughout.
  - RUN_S: `init_done_o=1` and `add_addr_ready_o=1`. Stays in RUN_S until reset.
- Output refill (RUN_S only):
  - When `out_val=0`, no read is in flight and `mem_cnt>0`: issue a read and decrement `mem_cnt`.
  - The next cycle, `out_val=1` and `out_addr` = the data read.
- Consume: `empty_addr_rd_ack_i & out_val` clears `out_val` at the clock edge.
- `empty_addr_o` is stable from the rise of val until the edge after ack. Insert samples it across several cycles.
- Add: `add_addr_val_i & add_addr_ready_o` writes `add_addr_i` at the write pointer and increments `mem_cnt`.
- Ack and add in the same cycle: both take effect independently.
- Add and refill read in the same cycle: `mem_cnt` is unchanged.
- Add when `free_cnt_o == DEPTH`: the write is dropped and `err_o` is set. This can only happen on a double free.
- `free_cnt_o = mem_cnt + out_val + read_in_flight`. It never exceeds DEPTH.
- Reset mid-operation: all state returns to INIT_S and the pool refills to all DEPTH addresses. Upstream must discard any outstanding pointers.

## Timing
- Reset values: `empty_addr_o=0`, `empty_addr_val_o=0`, `add_addr_ready_o=0`, `init_done_o=0`, `free_cnt_o=0`, `err_o=0`.
- Cycle 0 is the first edge after `rst_i` falls.
- Init occupies cycles 0..DEPTH-1. `init_done_o=1` from cycle DEPTH.
- The first read is issued in cycle DEPTH. `empty_addr_val_o=1` with address 0 from cycle DEPTH+1.
- Ack in cycle N: val=0 in N+1, with a read issued if `mem_cnt>0`. The next address is valid in N+2.
- Add into a fully empty pool in cycle N: read issued in N+1, val=1 in N+2.
- FIFO order: addresses are handed out in the order they were written.

## Configuration
- `EMPTY_PTR_DOUBLE_FREE_CHECK_EN`:
  - Defined: a DEPTH-bit `used` bitmap is maintained.
    - Set on ack for `out_addr`.
    - Cleared on an accepted add.
    - An add whose `used` bit is already 0 is dropped, neither written nor counted, and sets `err_o`.
    - The bitmap is cleared to all-free by reset.
  - Undefined: no bitmap is built. Adds are trusted, and `err_o` is only set by the overflow rule above.

## Test plan
Unless noted, `A_WIDTH=4` (DEPTH=16).
- Reset, then idle: `init_done_o` rises at cycle 16, val=1 with addr 0 at cycle 17, `free_cnt_o=16`.
- Ack 16 times, each as soon as val is seen: addrs 0..15 in order, 2-cycle spacing. Then val=0, `free_cnt_o=0`, `err_o=0`.
- Pool empty, add 9 in cycle N: val=1, addr 9 in N+2, `free_cnt_o=1`.
- Ack of addr 3 in the same cycle as add 3: `free_cnt_o` unchanged, and 3 appears again after 12 further acks.
- With the macro defined, after init with no acks, add 5: dropped, `err_o=1`, `free_cnt_o=16`. Without the macro: overflow drop, `err_o=1`.
- Assert reset mid-chain after 5 acks: outputs return to reset values, pool refills, and addr 0 is offered again at cycle 17.
